// File: rtl/chromite_trace_pkg.sv
// ---------------------------------------------------------------------------
// chromite_trace_pkg
// Shared definitions for the stage0 trace monitor: default parameter values,
// bit positions inside the event-kind mask, and the monitor FSM encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package chromite_trace_pkg;

  // Default sizing of the monitor and its event queue
  localparam int unsigned DEFAULT_XLEN  = 64;
  localparam int unsigned DEFAULT_DEPTH = 8;
  localparam int unsigned DEFAULT_SEQW  = 16;

  // Event-kind mask layout: {sfence, fence, w_epoch, e_epoch, flush}
  localparam int unsigned KIND_W      = 5;
  localparam int unsigned KIND_FLUSH  = 0;
  localparam int unsigned KIND_EEPOCH = 1;
  localparam int unsigned KIND_WEPOCH = 2;
  localparam int unsigned KIND_FENCE  = 3;
  localparam int unsigned KIND_SFENCE = 4;

  // Width of the saturating drop counter
  localparam int unsigned DROP_W = 16;

  // Monitor FSM states; the encoding is visible on the mon_state port
  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_ARM   = 2'd1,
    MON_RUN   = 2'd2,
    MON_DRAIN = 2'd3
  } mon_state_e;

endpackage

// File: rtl/trace_fifo.sv
// ---------------------------------------------------------------------------
// trace_fifo
// Synchronous FIFO holding packed trace events. A push into a full FIFO is
// only accepted when a pop happens in the same cycle; a pop from an empty
// FIFO is ignored, so there is no write-to-read bypass.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_data  write request and payload
//   i_pop           read request (advances the head)
//   o_data          head payload (raw storage, meaningful while !o_empty)
//   o_full, o_empty occupancy flags for the current cycle
//   o_level         current occupancy, 0..DEPTH
//   o_empty_next    FIFO will be empty after this cycle's push/pop
// ---------------------------------------------------------------------------
module trace_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level,
  output logic             o_empty_next
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;

  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LW-1:0]    w_level_next;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];

  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_push_ok = i_push && (!o_full || w_pop_ok);

  // Occupancy after this cycle's accepted push/pop
  always_comb begin
    w_level_next = r_level;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  assign o_empty_next = (w_level_next == '0);

  // Storage array is not reset; the pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_next;
    end
  end

endmodule

// File: rtl/stage0_trace_monitor.sv
// ---------------------------------------------------------------------------
// stage0_trace_monitor
// Watches stage0 control samples and queues a trace event whenever a flush,
// an epoch change or a rising fence/sfence is seen while the monitor runs.
// Coincident conditions merge into one event. Events carry the PC, the next
// PC, a kind mask and a sequence number; overflowing events are counted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mon_en                     monitor enable
//   pc, pc_d_in, pc_en         current PC, next-PC data, PC write enable
//   flush, e_epoch, w_epoch,
//   fence, sfence              stage0 control samples
//   evt_ready                  consumer accepts the head event
//   evt_valid                  an event is queued
//   evt_kind/pc/target/seq     head event fields (zero while empty)
//   fifo_level                 queued event count
//   drop_cnt                   saturating count of dropped events
//   mon_state                  IDLE=0, ARM=1, RUN=2, DRAIN=3
// ---------------------------------------------------------------------------
module stage0_trace_monitor
  import chromite_trace_pkg::*;
#(
  parameter  int unsigned XLEN  = DEFAULT_XLEN,
  parameter  int unsigned DEPTH = DEFAULT_DEPTH,
  parameter  int unsigned SEQW  = DEFAULT_SEQW,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mon_en,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   pc_d_in,
  input  logic              pc_en,
  input  logic              flush,
  input  logic              e_epoch,
  input  logic              w_epoch,
  input  logic              fence,
  input  logic              sfence,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [KIND_W-1:0] evt_kind,
  output logic [XLEN-1:0]   evt_pc,
  output logic [XLEN-1:0]   evt_target,
  output logic [SEQW-1:0]   evt_seq,
  output logic [LW-1:0]     fifo_level,
  output logic [DROP_W-1:0] drop_cnt,
  output logic [1:0]        mon_state
);

  // Packed event layout, LSB first: kind, pc, target, seq
  localparam int unsigned PW      = KIND_W + 2 * XLEN + SEQW;
  localparam int unsigned PC_LSB  = KIND_W;
  localparam int unsigned TGT_LSB = KIND_W + XLEN;
  localparam int unsigned SEQ_LSB = KIND_W + 2 * XLEN;

  mon_state_e        r_state;
  mon_state_e        w_state_next;
  logic              r_prev_e_epoch;
  logic              r_prev_w_epoch;
  logic              r_prev_fence;
  logic              r_prev_sfence;
  logic [SEQW-1:0]   r_seq;
  logic [DROP_W-1:0] r_drop_cnt;

  logic [KIND_W-1:0] w_kind;
  logic              w_detect;
  logic              w_pop;
  logic              w_drop;
  logic [XLEN-1:0]   w_target;
  logic [PW-1:0]     w_push_data;
  logic [PW-1:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_empty_next;

  // Edge/change detection against the previous-cycle samples, RUN only
  always_comb begin
    w_kind = '0;
    if (r_state == MON_RUN) begin
      w_kind[KIND_FLUSH]  = flush;
      w_kind[KIND_EEPOCH] = (e_epoch != r_prev_e_epoch);
      w_kind[KIND_WEPOCH] = (w_epoch != r_prev_w_epoch);
      w_kind[KIND_FENCE]  = fence  && !r_prev_fence;
      w_kind[KIND_SFENCE] = sfence && !r_prev_sfence;
    end
  end

  assign w_detect    = |w_kind;
  assign w_target    = pc_en ? pc_d_in : pc;
  assign w_push_data = {r_seq, w_target, pc, w_kind};

  // The head can only leave when it is visible, so an empty FIFO never
  // forwards a same-cycle push to the consumer
  assign w_pop  = !w_empty && evt_ready;
  assign w_drop = w_detect && w_full && !w_pop;

  trace_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_trace_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_detect),
    .i_data       (w_push_data),
    .i_pop        (w_pop),
    .o_data       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_level      (fifo_level),
    .o_empty_next (w_empty_next)
  );

  // Head fields are forced to zero whenever nothing is queued
  assign evt_valid  = !w_empty;
  assign evt_kind   = w_empty ? '0 : w_head[KIND_W-1:0];
  assign evt_pc     = w_empty ? '0 : w_head[PC_LSB +: XLEN];
  assign evt_target = w_empty ? '0 : w_head[TGT_LSB +: XLEN];
  assign evt_seq    = w_empty ? '0 : w_head[SEQ_LSB +: SEQW];
  assign drop_cnt   = r_drop_cnt;
  assign mon_state  = r_state;

  // Next-state logic; leaving RUN/DRAIN looks at occupancy after this
  // cycle's push and pop so the last event is never stranded
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      MON_IDLE:  if (mon_en) w_state_next = MON_ARM;
      MON_ARM:   w_state_next = MON_RUN;
      MON_RUN:   if (!mon_en) w_state_next = w_empty_next ? MON_IDLE : MON_DRAIN;
      MON_DRAIN: if (w_empty_next) w_state_next = MON_IDLE;
      default:   w_state_next = MON_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MON_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Previous samples track the inputs while armed or running, so the first
  // RUN cycle compares against the ARM-cycle values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_e_epoch <= 1'b0;
      r_prev_w_epoch <= 1'b0;
      r_prev_fence   <= 1'b0;
      r_prev_sfence  <= 1'b0;
    end else if (r_state == MON_ARM || r_state == MON_RUN) begin
      r_prev_e_epoch <= e_epoch;
      r_prev_w_epoch <= w_epoch;
      r_prev_fence   <= fence;
      r_prev_sfence  <= sfence;
    end
  end

  // Sequence numbers advance on every detection, dropped or not, so gaps
  // in the consumer's stream reveal lost events
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_detect) r_seq <= r_seq + SEQW'(1);
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_stage0_trace_monitor.sv
// ---------------------------------------------------------------------------
// tb_stage0_trace_monitor
// Self-checking bench for stage0_trace_monitor: directed scenarios with
// literal expectations followed by a randomized run, all compared each cycle
// against a queue-based behavioural model of the monitor.
// ---------------------------------------------------------------------------
module tb_stage0_trace_monitor;

  localparam int XLEN  = 64;
  localparam int DEPTH = 8;
  localparam int SEQW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mon_en;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_d_in;
  logic            pc_en;
  logic            flush;
  logic            e_epoch;
  logic            w_epoch;
  logic            fence;
  logic            sfence;
  logic            evt_ready;
  logic            evt_valid;
  logic [4:0]      evt_kind;
  logic [XLEN-1:0] evt_pc;
  logic [XLEN-1:0] evt_target;
  logic [SEQW-1:0] evt_seq;
  logic [3:0]      fifo_level;
  logic [15:0]     drop_cnt;
  logic [1:0]      mon_state;

  int testsRun    = 0;
  int testsFailed = 0;

  // Clock generation
  always #5 clk = ~clk;

  stage0_trace_monitor #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .SEQW  (SEQW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon_en     (mon_en),
    .pc         (pc),
    .pc_d_in    (pc_d_in),
    .pc_en      (pc_en),
    .flush      (flush),
    .e_epoch    (e_epoch),
    .w_epoch    (w_epoch),
    .fence      (fence),
    .sfence     (sfence),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_kind   (evt_kind),
    .evt_pc     (evt_pc),
    .evt_target (evt_target),
    .evt_seq    (evt_seq),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt),
    .mon_state  (mon_state)
  );

  // Behavioural model: a queue of pending events plus a few counters
  typedef struct packed {
    logic [4:0]      kind;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic [SEQW-1:0] seq;
  } evt_t;

  evt_t mq[$];
  int   mState;
  int   mSeq;
  int   mDrops;
  logic mPrevE, mPrevW, mPrevF, mPrevS;

  task automatic modelReset();
    mq.delete();
    mState = 0;
    mSeq   = 0;
    mDrops = 0;
    mPrevE = 1'b0;
    mPrevW = 1'b0;
    mPrevF = 1'b0;
    mPrevS = 1'b0;
  endtask

  // Advance the model by one clock edge using the current inputs
  task automatic modelStep();
    logic [4:0] kind;
    evt_t       e;
    kind = 5'd0;
    if (mState == 2) begin
      kind[0] = flush;
      kind[1] = (e_epoch != mPrevE);
      kind[2] = (w_epoch != mPrevW);
      kind[3] = fence && !mPrevF;
      kind[4] = sfence && !mPrevS;
    end
    if (mq.size() > 0 && evt_ready) void'(mq.pop_front());
    if (kind != 5'd0) begin
      if (mq.size() < DEPTH) begin
        e.kind = kind;
        e.pc   = pc;
        e.tgt  = pc_en ? pc_d_in : pc;
        e.seq  = SEQW'(mSeq);
        mq.push_back(e);
      end else if (mDrops < 65535) begin
        mDrops++;
      end
      mSeq = (mSeq + 1) % 65536;
    end
    if (mState == 1 || mState == 2) begin
      mPrevE = e_epoch;
      mPrevW = w_epoch;
      mPrevF = fence;
      mPrevS = sfence;
    end
    case (mState)
      0: mState = mon_en ? 1 : 0;
      1: mState = 2;
      2: if (!mon_en) mState = (mq.size() == 0) ? 0 : 3;
      default: mState = (mq.size() == 0) ? 0 : 3;
    endcase
  endtask

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic checkOutput();
    evt_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    checkVal("evt_valid",  64'(evt_valid),  64'(mq.size() > 0));
    checkVal("evt_kind",   64'(evt_kind),   64'(h.kind));
    checkVal("evt_pc",     evt_pc,          h.pc);
    checkVal("evt_target", evt_target,      h.tgt);
    checkVal("evt_seq",    64'(evt_seq),    64'(h.seq));
    checkVal("fifo_level", 64'(fifo_level), 64'(mq.size()));
    checkVal("drop_cnt",   64'(drop_cnt),   64'(mDrops));
    checkVal("mon_state",  64'(mon_state),  64'(mState));
  endtask

  task automatic applyStimulus(input logic en, input logic fl, input logic rdy);
    mon_en    = en;
    flush     = fl;
    evt_ready = rdy;
  endtask

  // One clock: model sees the inputs held across the edge, compare after it
  task automatic stepCycle();
    if (!rst_n) modelReset();
    else        modelStep();
    @(posedge clk);
    #1;
    if (!rst_n) modelReset();
    checkOutput();
  endtask

  task automatic clearInputs();
    mon_en    = 1'b0;
    pc        = '0;
    pc_d_in   = '0;
    pc_en     = 1'b0;
    flush     = 1'b0;
    e_epoch   = 1'b0;
    w_epoch   = 1'b0;
    fence     = 1'b0;
    sfence    = 1'b0;
    evt_ready = 1'b0;
  endtask

  // Reset, then enable and walk through ARM into RUN
  task automatic resetAndRun();
    clearInputs();
    rst_n = 1'b0;
    stepCycle();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    stepCycle();
    stepCycle();
    checkVal("reached_run", 64'(mon_state), 64'd2);
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    checkVal("reset_state", 64'(mon_state), 64'd0);
    checkVal("reset_level", 64'(fifo_level), 64'd0);
    checkVal("reset_valid", 64'(evt_valid), 64'd0);

    // Single flush in RUN
    rst_n  = 1'b1;
    mon_en = 1'b1;
    stepCycle();
    checkVal("arm_state", 64'(mon_state), 64'd1);
    stepCycle();
    checkVal("run_state", 64'(mon_state), 64'd2);
    checkVal("no_evt_from_arm", 64'(evt_valid), 64'd0);
    pc    = 64'h8000_0000;
    flush = 1'b1;
    stepCycle();
    checkVal("flush_valid", 64'(evt_valid), 64'd1);
    checkVal("flush_kind", 64'(evt_kind), 64'h01);
    checkVal("flush_pc", evt_pc, 64'h8000_0000);
    checkVal("flush_target", evt_target, 64'h8000_0000);
    checkVal("flush_seq", 64'(evt_seq), 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    checkVal("flush_popped", 64'(evt_valid), 64'd0);

    // Flush and epoch toggle coalesce, target from pc_d_in
    pc_en   = 1'b1;
    pc_d_in = 64'h8000_0004;
    flush   = 1'b1;
    e_epoch = 1'b1;
    evt_ready = 1'b0;
    stepCycle();
    checkVal("coalesce_kind", 64'(evt_kind), 64'h03);
    checkVal("coalesce_seq", 64'(evt_seq), 64'd1);
    checkVal("coalesce_target", evt_target, 64'h8000_0004);
    checkVal("coalesce_level", 64'(fifo_level), 64'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    stepCycle();
    checkVal("coalesce_popped", 64'(fifo_level), 64'd0);

    // Overflow: ten flushes into eight entries, then drain in order
    resetAndRun();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) stepCycle();
    checkVal("ovf_level", 64'(fifo_level), 64'd8);
    checkVal("ovf_drops", 64'(drop_cnt), 64'd2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkVal("drain_seq", 64'(evt_seq), 64'(i));
      stepCycle();
    end
    checkVal("drained_level", 64'(fifo_level), 64'd0);

    // Full with simultaneous pop and push keeps level and drop count
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) stepCycle();
    checkVal("refill_level", 64'(fifo_level), 64'd8);
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkVal("full_pushpop_level", 64'(fifo_level), 64'd8);
    end
    checkVal("full_pushpop_drops", 64'(drop_cnt), 64'd2);

    // DRAIN holds while stalled, ignores flush, returns to IDLE when empty
    resetAndRun();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycle();
    checkVal("drain_entered", 64'(mon_state), 64'd3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycle();
    stepCycle();
    checkVal("drain_held", 64'(mon_state), 64'd3);
    checkVal("drain_no_new", 64'(fifo_level), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycle();
    checkVal("drain_pop1_state", 64'(mon_state), 64'd3);
    checkVal("drain_pop1_level", 64'(fifo_level), 64'd2);
    stepCycle();
    stepCycle();
    checkVal("drain_idle", 64'(mon_state), 64'd0);
    checkVal("drain_empty", 64'(fifo_level), 64'd0);
    stepCycle();
    checkVal("idle_no_evt", 64'(evt_valid), 64'd0);

    // Asynchronous reset with five events queued
    resetAndRun();
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) stepCycle();
    checkVal("pre_reset_level", 64'(fifo_level), 64'd5);
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("async_valid", 64'(evt_valid), 64'd0);
    checkVal("async_level", 64'(fifo_level), 64'd0);
    checkVal("async_state", 64'(mon_state), 64'd0);
    checkVal("async_kind", 64'(evt_kind), 64'd0);
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    rst_n = 1'b1;

    // Randomized run against the model
    resetAndRun();
    for (int i = 0; i < 3000; i++) begin
      if (((i / 150) % 3) != 2) mon_en = ($urandom_range(0, 40) != 0);
      else                      mon_en = ($urandom_range(0, 9) == 0);
      pc        = {$urandom, $urandom};
      pc_d_in   = {$urandom, $urandom};
      pc_en     = $urandom_range(0, 1) == 1;
      flush     = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 7) == 0) e_epoch = ~e_epoch;
      if ($urandom_range(0, 7) == 0) w_epoch = ~w_epoch;
      fence     = $urandom_range(0, 2) == 0;
      sfence    = $urandom_range(0, 4) == 0;
      if (((i / 100) % 2) == 0) evt_ready = $urandom_range(0, 2) != 0;
      else                      evt_ready = $urandom_range(0, 5) == 0;
      rst_n = ($urandom_range(0, 499) != 0);
      stepCycle();
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
